// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - seven-segment glyph constants and pattern-to-hex lookup
package seven_segment_pkg;

  // Active-low {g,f,e,d,c,b,a}; must match the display ROM glyph table.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Returns {legal, value}; illegal patterns return all zeros.
  function automatic logic [4:0] seg_to_hex(input logic [6:0] seg_n);
    case (seg_n)
      SEG_0:   return {1'b1, 4'h0};
      SEG_1:   return {1'b1, 4'h1};
      SEG_2:   return {1'b1, 4'h2};
      SEG_3:   return {1'b1, 4'h3};
      SEG_4:   return {1'b1, 4'h4};
      SEG_5:   return {1'b1, 4'h5};
      SEG_6:   return {1'b1, 4'h6};
      SEG_7:   return {1'b1, 4'h7};
      SEG_8:   return {1'b1, 4'h8};
      SEG_9:   return {1'b1, 4'h9};
      SEG_A:   return {1'b1, 4'hA};
      SEG_B:   return {1'b1, 4'hB};
      SEG_C:   return {1'b1, 4'hC};
      SEG_D:   return {1'b1, 4'hD};
      SEG_E:   return {1'b1, 4'hE};
      SEG_F:   return {1'b1, 4'hF};
      default: return 5'h00;
    endcase
  endfunction

endpackage

// File: rtl/seven_segment_glyph_decoder.sv
// rtl/seven_segment_glyph_decoder.sv - combinational seven-segment pattern to {legal, value}
module seven_segment_glyph_decoder
  import seven_segment_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic       legal_o,
  output logic [3:0] value_o
);

  assign {legal_o, value_o} = seg_to_hex(pattern_i);

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// rtl/seven_segment_scan_decoder.sv - rebuilds per-digit hex values from a multiplexed seven-segment bus
module seven_segment_scan_decoder
  import seven_segment_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_n,
  input  logic [N_DIGITS-1:0]   an_n,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic [N_DIGITS-1:0]   code_err,
  output logic                  update,
  output logic [2:0]            update_idx
);

  localparam int              CW      = $clog2(STABLE_CYCLES + 1);
  localparam int              SW      = N_DIGITS + 7;
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);

  logic [SW-1:0]         sample, prev_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  cap_q, cap_d;
  logic [N_DIGITS-1:0]   sel;
  logic                  one_hot;
  logic [2:0]            sel_idx;
  logic                  accept;
  logic                  glyph_legal;
  logic [3:0]            glyph_value;
  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic [N_DIGITS-1:0]   valid_q, valid_d;
  logic [N_DIGITS-1:0]   err_q, err_d;
  logic                  update_q, update_d;
  logic [2:0]            idx_q, idx_d;

  seven_segment_glyph_decoder u_glyph (
    .pattern_i (seg_n),
    .legal_o   (glyph_legal),
    .value_o   (glyph_value)
  );

  assign sample  = {an_n, seg_n};
  assign sel     = ~an_n;
  assign one_hot = (sel != '0) && ((sel & (sel - N_DIGITS'(1))) == '0);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (sel[i]) sel_idx = 3'(i);
    end
  end

  // Run tracking: a changed legal sample restarts at 1, so a change on the saturating edge never accepts.
  always_comb begin
    cnt_d  = cnt_q;
    cap_d  = cap_q;
    accept = 1'b0;
    if (!one_hot) begin
      cnt_d = '0;
      cap_d = 1'b0;
    end else if (sample != prev_q) begin
      cnt_d = CW'(1);
      cap_d = 1'b0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (one_hot && (cnt_d == CNT_MAX) && !cap_d) begin
      accept = 1'b1;
      cap_d  = 1'b1;
    end
  end

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    update_d = 1'b0;
    idx_d    = idx_q;
    if (accept) begin
      update_d = 1'b1;
      idx_d    = sel_idx;
      for (int i = 0; i < N_DIGITS; i++) begin
        if (sel[i]) begin
          if (glyph_legal) digits_d[4*i +: 4] = glyph_value;
          valid_d[i] = glyph_legal;
          err_d[i]   = !glyph_legal;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q   <= '1;
      cnt_q    <= '0;
      cap_q    <= 1'b0;
      digits_q <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      update_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      prev_q   <= sample;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      update_q <= update_d;
      idx_q    <= idx_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign code_err    = err_q;
  assign update      = update_q;
  assign update_idx  = idx_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// tb/tb_seven_segment_scan_decoder.sv - self-checking bench for seven_segment_scan_decoder
module tb_seven_segment_scan_decoder;

  localparam int N = 4;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [6:0]     seg_n = 7'h7F;
  logic [N-1:0]   an_n = '1;
  logic [4*N-1:0] digits;
  logic [N-1:0]   digit_valid;
  logic [N-1:0]   code_err;
  logic           update;
  logic [2:0]     update_idx;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [N+6:0]   hist[$];
  logic [4*N-1:0] m_digits;
  logic [N-1:0]   m_valid, m_err;
  logic           m_update;
  logic [2:0]     m_idx;
  int             run, pos, val;

  seven_segment_scan_decoder #(.N_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .digits      (digits),
    .digit_valid (digit_valid),
    .code_err    (code_err),
    .update      (update),
    .update_idx  (update_idx)
  );

  always #5 clk = ~clk;

  function automatic bit legal_an(input logic [N-1:0] a);
    return $countones(~a) == 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a digit is accepted on the edge where the trailing run of identical legal samples reaches exactly S.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      m_digits = '0;
      m_valid  = '0;
      m_err    = '0;
      m_update = 1'b0;
      m_idx    = '0;
    end else begin
      hist.push_back({an_n, seg_n});
      if (hist.size() > 16) void'(hist.pop_front());
      run = 0;
      for (int k = hist.size() - 1; k >= 0; k--) begin
        if (legal_an(hist[k][N+6:7]) && hist[k] == hist[hist.size()-1]) run++;
        else break;
      end
      m_update = (run == S);
      if (m_update) begin
        pos = 0;
        for (int j = 0; j < N; j++) if (!an_n[j]) pos = j;
        val = -1;
        for (int j = 0; j < 16; j++) if (glyph_tab[j] == seg_n) val = j;
        m_idx = 3'(pos);
        if (val >= 0) begin
          m_digits[4*pos +: 4] = 4'(val);
          m_valid[pos] = 1'b1;
          m_err[pos]   = 1'b0;
        end else begin
          m_valid[pos] = 1'b0;
          m_err[pos]   = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("digits", 32'(digits), 32'(m_digits));
    check("digit_valid", 32'(digit_valid), 32'(m_valid));
    check("code_err", 32'(code_err), 32'(m_err));
    check("update", 32'(update), 32'(m_update));
    if (m_update) check("update_idx", 32'(update_idx), 32'(m_idx));
    if (update === 1'b1) pulses++;
  end

  task automatic hold(input logic [N-1:0] a, input logic [6:0] s, input int n);
    an_n  = a;
    seg_n = s;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_digits", 32'(digits), 32'h0);
    check("reset_update", 32'(update), 32'h0);
    reset = 1'b0;

    hold(4'b1110, 7'h24, 4);
    check("t1_update", 32'(update), 32'h1);
    check("t1_idx", 32'(update_idx), 32'h0);
    check("t1_digits", 32'(digits), 32'h0002);
    check("t1_valid", 32'(digit_valid), 32'h1);
    hold(4'b1110, 7'h24, 10);
    check("t1_pulses", 32'(pulses), 32'd1);
    check("t1_quiet", 32'(update), 32'h0);

    hold(4'b1110, 7'h79, 5);
    hold(4'b1101, 7'h08, 5);
    hold(4'b1011, 7'h46, 5);
    hold(4'b0111, 7'h0E, 5);
    check("scan_digits", 32'(digits), 32'hFCA1);
    check("scan_valid", 32'(digit_valid), 32'hF);

    hold(4'b1011, 7'h7F, 6);
    check("blank_err", 32'(code_err), 32'h4);
    check("blank_valid", 32'(digit_valid), 32'hB);
    check("blank_digits", 32'(digits), 32'hFCA1);
    check("blank_pulses", 32'(pulses), 32'd6);
    hold(4'b1011, 7'h30, 4);
    check("fix_digits", 32'(digits), 32'hF3A1);
    check("fix_err", 32'(code_err), 32'h0);
    check("fix_valid", 32'(digit_valid), 32'hF);

    hold(4'b1101, 7'h12, 3);
    hold(4'b1101, 7'h02, 1);
    hold(4'b1101, 7'h12, 3);
    check("glitch_hold", 32'(digits), 32'hF3A1);
    check("glitch_pulses", 32'(pulses), 32'd7);
    hold(4'b1101, 7'h12, 1);
    check("glitch_digits", 32'(digits), 32'hF351);
    check("glitch_update", 32'(update), 32'h1);

    hold(4'b1100, 7'h00, 10);
    check("ghost_pulses", 32'(pulses), 32'd8);
    hold(4'b1111, 7'h00, 10);
    check("blank_an_pulses", 32'(pulses), 32'd8);
    check("ghost_digits", 32'(digits), 32'hF351);

    hold(4'b1110, 7'h06, 3);
    #2 reset = 1'b1;
    #1;
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_valid", 32'(digit_valid), 32'h0);
    check("rst_err", 32'(code_err), 32'h0);
    check("rst_update", 32'(update), 32'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_early", 32'(update), 32'h0);
    check("rst_no_early_digits", 32'(digits), 32'h0);
    @(negedge clk);
    check("rst_accept", 32'(update), 32'h1);
    check("rst_accept_digits", 32'(digits), 32'h000E);
    check("rst_accept_valid", 32'(digit_valid), 32'h1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan_decoder.md
Name: seven_segment_scan_decoder

Overview:
- Receive end of a time-multiplexed seven-segment display bus: active-low segment lines plus active-low digit-select lines.
- Reconstructs the hex value shown on each digit position; flags positions whose pattern is not a legal 0-F glyph.
- Used to self-check display drivers and ROM glyph tables in loopback, and to read another board's display bus.
- Glyph encoding is identical to the team's seven-segment ROM: seg[6:0] = {g,f,e,d,c,b,a}, active low.

Parameters:
- N_DIGITS, 4, number of digit-select lines / reconstructed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is accepted (>=1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- seg_n  input  7  segment lines {g,f,e,d,c,b,a}, active low.
- an_n  input  N_DIGITS  digit selects, active low; bit i low = digit i driven.
- digits  output  4*N_DIGITS  decoded values; digit i at [4i+3:4i].
- digit_valid  output  N_DIGITS  bit i = digits[i] holds a legal decode.
- code_err  output  N_DIGITS  bit i = last accepted pattern on digit i was illegal.
- update  output  1  one-cycle pulse when any digit is accepted.
- update_idx  output  3  index of the accepted digit; meaningful while update=1.

Behaviour:
- Reset (asynchronous): digits=0, digit_valid=0, code_err=0, update=0, update_idx=0. Internal prev sample=all ones, run counter=0, captured=0. Reset mid-dwell discards the partial run.
- Sample legal iff exactly one an_n bit is low. Zero or more than one low = blanking or ghosting: counter<=0, captured<=0, no acceptance.
- Run counter, saturating at STABLE_CYCLES, width clog2(STABLE_CYCLES+1):
  - legal sample equal to prev {an_n,seg_n}: counter+1.
  - legal sample differing from prev: counter<=1, captured<=0.
  - prev registers are updated every cycle.
- Acceptance edge: the edge at which the counter reaches STABLE_CYCLES with captured=0.
  - Acceptance sets captured=1, so there is exactly one acceptance per dwell. A held input never re-pulses.
  - A change to seg_n or an_n starts a new dwell, which may be accepted again even for the same digit.
- Latency: input held stable from before edge 1 gives registered outputs and update visible after edge STABLE_CYCLES. With STABLE_CYCLES=1, acceptance happens on the first legal sample.
- Acceptance of digit i, pattern p:
  - p in glyph table: digits[i]<=value, digit_valid[i]<=1, code_err[i]<=0.
  - p not in table (including all-off 7'h7F): digits[i] unchanged, digit_valid[i]<=0, code_err[i]<=1.
  - update<=1 and update_idx<=i for one cycle. Other digits are untouched.
- Glyph table (hex value: seg_n):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - Any other pattern is illegal.
- Simultaneous events: reset dominates. Input change on the same edge the counter would saturate counts as a new run (counter=1, no acceptance).
- Inputs are assumed synchronous to clk. Any synchroniser sits outside this block.

Decomposition:
- Package seven_segment_pkg:
  - glyph constants SEG_0..SEG_F.
  - function seg_to_hex returning {legal, value[3:0]}.
  - SEG_BLANK = 7'h7F.
- Optional sub-module seven_segment_glyph_decoder: combinational pattern to {legal, value}. It is shared with future display-checking blocks.
- The one-hot-low detect and index encode stay in the top block.

Test Plan:
- Reset then hold an_n=4'b1110, seg_n=7'h24 for 4 cycles -> after edge 4: digits[3:0]=2, digit_valid=4'b0001, update pulses once with update_idx=0. Hold 10 more cycles -> no further pulse.
- Scan digits 0..3 with 5-cycle dwells showing 1,A,C,F (7'h79, 08, 46, 0E) -> digits=16'hFCA1, digit_valid=4'hF, four update pulses with idx 0,1,2,3.
- Digit 2 shows 7'h7F (blank) for 6 cycles -> code_err=4'b0100, digit_valid[2]=0, digits[11:8] keeps its prior value. Then 7'h30 for 4 cycles -> digits[11:8]=3, code_err[2]=0.
- Glitch: an_n=4'b1101, seg_n=7'h12 for 3 cycles, then one cycle of 7'h02, then 7'h12 again -> no acceptance until 4 cycles after the return. Final digits[7:4]=5.
- Ghosting: an_n=4'b1100 or 4'b1111 held 20 cycles with seg_n=7'h00 -> no update, outputs unchanged.
- Assert reset on the cycle before a pending acceptance (counter=3) -> outputs all zero, no update pulse. After release, a full 4 fresh cycles are needed before acceptance.
